// File: rtl/pong_field_if.sv
// Pixel-stream, button and VGA-pin bundle for pong_field; master is the source/sink side, slave is the engine.
// Carries no handshake: every signal is sampled or presented once per pixel clock.
interface pong_field_if #(
   parameter int COLOR_W = 10
);
   logic [9:0]         sx;
   logic [9:0]         sy;
   logic               de;
   logic               hsync_in;
   logic               vsync_in;
   logic               btn_l_up;
   logic               btn_l_dn;
   logic               btn_r_up;
   logic               btn_r_dn;
   logic [COLOR_W-1:0] vga_r;
   logic [COLOR_W-1:0] vga_g;
   logic [COLOR_W-1:0] vga_b;
   logic               vga_hsync;
   logic               vga_vsync;
   logic [3:0]         score_l;
   logic [3:0]         score_r;
   logic               game_over;

   modport master (
      output sx, sy, de, hsync_in, vsync_in,
      output btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
      input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
      input  score_l, score_r, game_over
   );

   modport slave (
      input  sx, sy, de, hsync_in, vsync_in,
      input  btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
      output vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
      output score_l, score_r, game_over
   );
endinterface

// File: rtl/pong_field.sv
// pong_field: per-frame pong engine (ball, paddles, score, SERVE/PLAY/OVER) and 1-cycle registered pixel painter.
// No backpressure (free-running pixel stream); define PONG_AUTOPADDLE_EN to let the right paddle track the ball.
module pong_field #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 48,
   parameter int PADDLE_XL    = 16,
   parameter int PADDLE_XR    = 616,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int SCORE_MAX    = 9,
   parameter int COLOR_W      = 10
) (
   input  logic        clock_25M,
   input  logic        reset_n,
   pong_field_if.slave io
);

   typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_OVER} state_e;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       dx_neg;
      logic       dy_neg;
   } ball_t;

   localparam int                  CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [CNT_W-1:0]    SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [9:0]          BALL_X0    = 10'(H_RES / 2 - BALL_SIZE / 2);
   localparam logic [9:0]          BALL_Y0    = 10'(V_RES / 2 - BALL_SIZE / 2);
   localparam logic [9:0]          PAD_Y0     = 10'(V_RES / 2 - PADDLE_H / 2);
   localparam logic signed [10:0]  SPD        = 11'(BALL_SPEED);
   localparam logic signed [10:0]  X_MAX      = 11'(H_RES - BALL_SIZE);
   localparam logic signed [10:0]  Y_MAX      = 11'(V_RES - BALL_SIZE);
   localparam logic signed [10:0]  X_HIT_L    = 11'(PADDLE_XL + PADDLE_W);
   localparam logic signed [10:0]  X_HIT_R    = 11'(PADDLE_XR - BALL_SIZE);
   localparam logic [COLOR_W-1:0]  C_MSB      = {1'b1, {(COLOR_W-1){1'b0}}};
   localparam ball_t               BALL_RST   = '{x: BALL_X0, y: BALL_Y0, dx_neg: 1'b0, dy_neg: 1'b0};

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   ball_t              ball_q, ball_d;
   logic [9:0]         pad_l_q, pad_l_d;
   logic [9:0]         pad_r_q, pad_r_d;
   logic [3:0]         score_l_q, score_l_d;
   logic [3:0]         score_r_q, score_r_d;
   logic               over_q, over_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic               hs_q, vs_q;

   logic               frame_tick;
   logic               any_btn;
   logic               r_up, r_dn;
   logic               ov_l, ov_r;
   logic signed [10:0] nx, ny;
   logic               dy_neg_n;
   logic [10:0]        sx11, sy11, by11;
   logic               in_ball, in_pad_l, in_pad_r, in_net;

   function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
      int t;
      t = int'(y);
      if (up && !dn) begin
         t = t - PADDLE_SPEED;
      end else if (dn && !up) begin
         t = t + PADDLE_SPEED;
      end
      if (t < 0) begin
         t = 0;
      end else if (t > V_RES - PADDLE_H) begin
         t = V_RES - PADDLE_H;
      end
      return 10'(t);
   endfunction

   assign frame_tick = (io.sx == 10'd0) && (io.sy == 10'(V_RES));
   assign any_btn    = io.btn_l_up | io.btn_l_dn | io.btn_r_up | io.btn_r_dn;

`ifdef PONG_AUTOPADDLE_EN
   // Error is target paddle y (ball centre aligned to paddle centre) minus current paddle y.
   localparam logic signed [11:0] R_OFS  = 12'(BALL_SIZE / 2 - PADDLE_H / 2);
   localparam logic signed [11:0] R_DEAD = 12'(PADDLE_SPEED);
   logic signed [11:0] r_err;
   assign r_err = $signed({2'b00, ball_q.y}) + R_OFS - $signed({2'b00, pad_r_q});
   assign r_up  = (r_err < -R_DEAD);
   assign r_dn  = (r_err > R_DEAD);
`else
   assign r_up  = io.btn_r_up;
   assign r_dn  = io.btn_r_dn;
`endif

   assign by11 = {1'b0, ball_q.y};
   assign ov_l = (by11 + 11'(BALL_SIZE) > {1'b0, pad_l_q}) && (by11 < {1'b0, pad_l_q} + 11'(PADDLE_H));
   assign ov_r = (by11 + 11'(BALL_SIZE) > {1'b0, pad_r_q}) && (by11 < {1'b0, pad_r_q} + 11'(PADDLE_H));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ball_d    = ball_q;
      pad_l_d   = pad_l_q;
      pad_r_d   = pad_r_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      nx        = $signed({1'b0, ball_q.x}) + (ball_q.dx_neg ? -SPD : SPD);
      ny        = $signed({1'b0, ball_q.y}) + (ball_q.dy_neg ? -SPD : SPD);
      dy_neg_n  = ball_q.dy_neg;
      if (ny < 0) begin
         ny       = '0;
         dy_neg_n = 1'b0;
      end else if (ny > Y_MAX) begin
         ny       = Y_MAX;
         dy_neg_n = 1'b1;
      end

      if (frame_tick) begin
         pad_l_d = pad_step(pad_l_q, io.btn_l_up, io.btn_l_dn);
         pad_r_d = pad_step(pad_r_q, r_up, r_dn);
         case (state_q)
            ST_SERVE: begin
               ball_d.x = BALL_X0;
               ball_d.y = BALL_Y0;
               if (cnt_q == SERVE_LAST) begin
                  state_d = ST_PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_PLAY: begin
               ball_d.y      = ny[9:0];
               ball_d.dy_neg = dy_neg_n;
               // Paddle hits win over misses; a miss recentres the ball heading toward whoever conceded.
               if (ball_q.dx_neg && (nx <= X_HIT_L) && ov_l) begin
                  ball_d.x      = X_HIT_L[9:0];
                  ball_d.dx_neg = 1'b0;
               end else if (!ball_q.dx_neg && (nx >= X_HIT_R) && ov_r) begin
                  ball_d.x      = X_HIT_R[9:0];
                  ball_d.dx_neg = 1'b1;
               end else if (nx < 0) begin
                  score_r_d = score_r_q + 4'd1;
                  ball_d    = '{x: BALL_X0, y: BALL_Y0, dx_neg: 1'b1, dy_neg: dy_neg_n};
                  cnt_d     = '0;
                  state_d   = (score_r_d == 4'(SCORE_MAX)) ? ST_OVER : ST_SERVE;
               end else if (nx > X_MAX) begin
                  score_l_d = score_l_q + 4'd1;
                  ball_d    = '{x: BALL_X0, y: BALL_Y0, dx_neg: 1'b0, dy_neg: dy_neg_n};
                  cnt_d     = '0;
                  state_d   = (score_l_d == 4'(SCORE_MAX)) ? ST_OVER : ST_SERVE;
               end else begin
                  ball_d.x = nx[9:0];
               end
            end
            ST_OVER: begin
               if (any_btn) begin
                  score_l_d = '0;
                  score_r_d = '0;
                  cnt_d     = '0;
                  state_d   = ST_SERVE;
               end
            end
            default: state_d = ST_SERVE;
         endcase
      end
      over_d = (state_d == ST_OVER);
   end

   assign sx11     = {1'b0, io.sx};
   assign sy11     = {1'b0, io.sy};
   assign in_ball  = (state_q != ST_OVER)
                   && (sx11 >= {1'b0, ball_q.x}) && (sx11 < {1'b0, ball_q.x} + 11'(BALL_SIZE))
                   && (sy11 >= {1'b0, ball_q.y}) && (sy11 < {1'b0, ball_q.y} + 11'(BALL_SIZE));
   assign in_pad_l = (sx11 >= 11'(PADDLE_XL)) && (sx11 < 11'(PADDLE_XL + PADDLE_W))
                   && (sy11 >= {1'b0, pad_l_q}) && (sy11 < {1'b0, pad_l_q} + 11'(PADDLE_H));
   assign in_pad_r = (sx11 >= 11'(PADDLE_XR)) && (sx11 < 11'(PADDLE_XR + PADDLE_W))
                   && (sy11 >= {1'b0, pad_r_q}) && (sy11 < {1'b0, pad_r_q} + 11'(PADDLE_H));
   assign in_net   = ((io.sx == 10'(H_RES / 2 - 1)) || (io.sx == 10'(H_RES / 2))) && !io.sy[3];

   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (io.de) begin
         if (in_ball || in_pad_l || in_pad_r) begin
            r_d = '1;
            g_d = '1;
            b_d = '1;
         end else if (in_net) begin
            r_d = C_MSB;
            g_d = C_MSB;
            b_d = C_MSB;
         end else begin
            b_d = C_MSB;
         end
      end
   end

   always_ff @(posedge clock_25M or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_SERVE;
         cnt_q     <= '0;
         ball_q    <= BALL_RST;
         pad_l_q   <= PAD_Y0;
         pad_r_q   <= PAD_Y0;
         score_l_q <= '0;
         score_r_q <= '0;
         over_q    <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ball_q    <= ball_d;
         pad_l_q   <= pad_l_d;
         pad_r_q   <= pad_r_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         over_q    <= over_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
         hs_q      <= io.hsync_in;
         vs_q      <= io.vsync_in;
      end
   end

   assign io.vga_r     = r_q;
   assign io.vga_g     = g_q;
   assign io.vga_b     = b_q;
   assign io.vga_hsync = hs_q;
   assign io.vga_vsync = vs_q;
   assign io.score_l   = score_l_q;
   assign io.score_r   = score_r_q;
   assign io.game_over = over_q;

endmodule

// File: tb/tb_pong_field.sv
// Directed bench for pong_field with SERVE_FRAMES=2, SCORE_MAX=2; frame ticks are forced by driving (0, V_RES).
// Ball and paddle positions are observed through painted pixels.
module tb_pong_field;

   localparam logic [29:0] C_WHT = {30{1'b1}};
   localparam logic [29:0] C_BG  = 30'd512;
   localparam logic [29:0] C_NET = {10'd512, 10'd512, 10'd512};
   localparam logic [29:0] C_OFF = 30'd0;

   typedef struct {
      string       name;
      int          x;
      int          y;
      logic        de;
      logic        hs;
      logic        vs;
      logic [29:0] rgb;
      logic [1:0]  syn;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pong_field_if #(.COLOR_W(10)) io ();

   pong_field #(.SERVE_FRAMES(2), .SCORE_MAX(2)) dut (
      .clock_25M (clk),
      .reset_n   (rst_n),
      .io        (io.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      io.sx = 10'd700; io.sy = 10'd500; io.de = 1'b0;
      io.hsync_in = 1'b1; io.vsync_in = 1'b1;
   endtask

   task automatic tick();
      @(negedge clk);
      io.sx = 10'd0; io.sy = 10'd480; io.de = 1'b0;
      @(negedge clk);
      io.sx = 10'd700; io.sy = 10'd500;
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic probe(input int x, input int y, input logic d, input logic hs, input logic vs,
                        output logic [29:0] rgb, output logic [1:0] syn);
      @(negedge clk);
      io.sx = 10'(x); io.sy = 10'(y); io.de = d; io.hsync_in = hs; io.vsync_in = vs;
      @(negedge clk);
      rgb = {io.vga_r, io.vga_g, io.vga_b};
      syn = {io.vga_hsync, io.vga_vsync};
      idle();
   endtask

   task automatic chk_px(input string name, input int x, input int y, input logic exp_white);
      logic [29:0] rgb;
      logic [1:0]  syn;
      probe(x, y, 1'b1, 1'b1, 1'b1, rgb, syn);
      chk(name, {31'd0, rgb == C_WHT}, {31'd0, exp_white});
   endtask

   task automatic chk_ball(input string name, input int x, input int y);
      chk_px({name, "_tl"}, x, y, 1'b1);
      chk_px({name, "_br"}, x + 7, y + 7, 1'b1);
      chk_px({name, "_left"}, x - 1, y, 1'b0);
      chk_px({name, "_above"}, x, y - 1, 1'b0);
   endtask

   vec_t        tbl [18];
   logic [29:0] rgb;
   logic [1:0]  syn;

   initial begin
      tbl[0]  = '{"ball_tl",      316, 236, 1'b1, 1'b1, 1'b1, C_WHT, 2'b11};
      tbl[1]  = '{"ball_br",      323, 243, 1'b1, 1'b1, 1'b1, C_WHT, 2'b11};
      tbl[2]  = '{"ball_r_out",   324, 236, 1'b1, 1'b1, 1'b1, C_BG,  2'b11};
      tbl[3]  = '{"ball_l_out",   315, 243, 1'b1, 1'b1, 1'b1, C_BG,  2'b11};
      tbl[4]  = '{"net_on",       319,   0, 1'b1, 1'b1, 1'b1, C_NET, 2'b11};
      tbl[5]  = '{"net_gap",      320,   8, 1'b1, 1'b1, 1'b1, C_BG,  2'b11};
      tbl[6]  = '{"ball_on_net",  320, 240, 1'b1, 1'b1, 1'b1, C_WHT, 2'b11};
      tbl[7]  = '{"padl_tl",       16, 216, 1'b1, 1'b1, 1'b1, C_WHT, 2'b11};
      tbl[8]  = '{"padl_br",       23, 263, 1'b1, 1'b1, 1'b1, C_WHT, 2'b11};
      tbl[9]  = '{"padl_x_out",    24, 216, 1'b1, 1'b1, 1'b1, C_BG,  2'b11};
      tbl[10] = '{"padl_y_out",    16, 264, 1'b1, 1'b1, 1'b1, C_BG,  2'b11};
      tbl[11] = '{"padr_mid",     620, 240, 1'b1, 1'b1, 1'b1, C_WHT, 2'b11};
      tbl[12] = '{"padr_above",   623, 215, 1'b1, 1'b1, 1'b1, C_BG,  2'b11};
      tbl[13] = '{"blank_ball",   316, 236, 1'b0, 1'b1, 1'b1, C_OFF, 2'b11};
      tbl[14] = '{"hsync_pass",   100, 100, 1'b0, 1'b0, 1'b1, C_OFF, 2'b01};
      tbl[15] = '{"vsync_pass",   100, 100, 1'b0, 1'b1, 1'b0, C_OFF, 2'b10};
      tbl[16] = '{"corner",       639, 479, 1'b1, 1'b1, 1'b1, C_BG,  2'b11};
      tbl[17] = '{"net_on2",      320,  16, 1'b1, 1'b1, 1'b1, C_NET, 2'b11};

      idle();
      io.btn_l_up = 1'b0; io.btn_l_dn = 1'b0; io.btn_r_up = 1'b0; io.btn_r_dn = 1'b0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_score_l", io.score_l, 0);
      chk("rst_score_r", io.score_r, 0);
      chk("rst_game_over", io.game_over, 0);
      chk("rst_syncs", {io.vga_hsync, io.vga_vsync}, 2'b11);
      chk("rst_rgb", {io.vga_r, io.vga_g, io.vga_b}, C_OFF);
      rst_n = 1'b1;

      // Serve hold then first move.
      tick(); chk_ball("serve1", 316, 236);
      tick(); chk_ball("serve2", 316, 236);
      tick(); chk_ball("play1", 318, 238);

      io.btn_l_up = 1'b1; ticks(60);
      chk_px("padl_top", 16, 0, 1'b1);
      chk_px("padl_bot", 16, 47, 1'b1);
      chk_px("padl_below", 16, 48, 1'b0);
      chk_ball("play61", 438, 358);
      io.btn_l_dn = 1'b1; ticks(3);
      chk_px("both_top", 16, 0, 1'b1);
      chk_px("both_below", 16, 48, 1'b0);
      io.btn_l_up = 1'b0; tick(); io.btn_l_dn = 1'b0;
      chk_px("dn_above", 16, 3, 1'b0);
      chk_px("dn_top", 16, 4, 1'b1);
      chk_px("dn_bot", 16, 51, 1'b1);
      chk_px("dn_below", 16, 52, 1'b0);
      io.btn_r_up = 1'b1; ticks(3); io.btn_r_up = 1'b0;
      chk_px("padr_above", 616, 203, 1'b0);
      chk_px("padr_top", 616, 204, 1'b1);
      chk_px("padr_bot", 616, 251, 1'b1);
      chk_px("padr_below", 616, 252, 1'b0);

      // Bottom wall: y reaches 472, is clamped there once more, then heads up.
      ticks(50); chk_ball("wall_reach", 552, 472);
      tick();    chk_ball("wall_clamp", 554, 472);
      tick();    chk_ball("wall_up", 556, 470);

      ticks(38); chk_ball("pre_miss", 632, 394);
      chk("pre_miss_score_l", io.score_l, 0);
      tick();
      chk("miss_score_l", io.score_l, 1);
      chk("miss_score_r", io.score_r, 0);
      chk("miss_game_over", io.game_over, 0);
      chk_ball("recentre", 316, 236);
      tick(); chk_ball("serve_hold", 316, 236);
      tick(); tick(); chk_ball("serve_dir", 318, 234);

      // Second rally: top wall at y=0, then another right-side miss ends the game.
      ticks(157); chk_ball("pre_miss2", 632, 78);
      @(negedge clk);
      io.sx = 10'd0; io.sy = 10'd480; io.de = 1'b0;
      chk("over_not_early", io.game_over, 0);
      @(negedge clk);
      io.sx = 10'd700; io.sy = 10'd500;
      chk("over_set", io.game_over, 1);
      chk("over_score_l", io.score_l, 2);
      chk("over_score_r", io.score_r, 0);
      chk_px("over_no_ball", 316, 236, 1'b0);
      chk_px("over_padl", 16, 4, 1'b1);
      tick(); chk("over_hold", io.game_over, 1);
      io.btn_l_dn = 1'b1; tick(); io.btn_l_dn = 1'b0;
      chk("restart_over", io.game_over, 0);
      chk("restart_score_l", io.score_l, 0);
      chk_px("restart_pad_top", 16, 8, 1'b1);
      chk_px("restart_pad_above", 16, 7, 1'b0);
      tick(); chk_ball("restart_serve", 316, 236);
      tick(); tick(); chk_ball("restart_play", 318, 238);

      // Asynchronous reset in the middle of a visible pixel.
      probe(100, 100, 1'b1, 1'b0, 1'b0, rgb, syn);
      chk("pre_rst_rgb", {2'b00, rgb}, C_BG);
      chk("pre_rst_sync", syn, 2'b00);
      @(negedge clk);
      io.sx = 10'd100; io.sy = 10'd100; io.de = 1'b1; io.hsync_in = 1'b0; io.vsync_in = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_rgb", {io.vga_r, io.vga_g, io.vga_b}, C_OFF);
      chk("mid_rst_sync", {io.vga_hsync, io.vga_vsync}, 2'b11);
      chk("mid_rst_over", io.game_over, 0);
      idle();
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         probe(tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].hs, tbl[i].vs, rgb, syn);
         chk({tbl[i].name, "_rgb"}, {2'b00, rgb}, {2'b00, tbl[i].rgb});
         chk({tbl[i].name, "_sync"}, {30'd0, syn}, {30'd0, tbl[i].syn});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
